// File: rtl/axis_header_insert_pkg.sv
// Shared state encoding and byte-enable helpers for the header inserter.
// Helpers work on a fixed maximum lane count so any stream width up to MAX_BYTES can use them.
package axis_header_insert_pkg;

  localparam int MAX_BYTES = 64;
  localparam int CNT_W     = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    TAIL   = 2'd2
  } state_t;

  // Number of set enables (keep patterns are contiguous, so this is the byte count).
  function automatic cnt_t keep_to_count(input logic [MAX_BYTES-1:0] keep);
    cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) c = c + cnt_t'(1);
    end
    return c;
  endfunction

  // 'cnt' ones packed against the MSB of an n-lane keep field.
  function automatic logic [MAX_BYTES-1:0] count_to_keep(input cnt_t cnt, input int n);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((i < n) && (i >= n - int'(cnt))) k[i] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_header_insert.sv
// Prepends a 1..N byte header to an AXI-stream packet and repacks into full beats; payload passes
// combinationally (0 cycles), a leftover residue costs one extra TAIL beat; stalls follow ready_in directly.
module axis_header_insert
  import axis_header_insert_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_in,
  input  logic                       last_in,
  output logic                       ready_out,
  input  logic                       valid_insert,
  input  logic [DATA_WIDTH-1:0]      data_insert,
  input  logic [DATA_BYTE_WIDTH-1:0] keep_insert,
  output logic                       ready_insert,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [DATA_BYTE_WIDTH-1:0] keep_out,
  output logic                       last_out,
  input  logic                       ready_in
);

  localparam int   W     = DATA_WIDTH;
  localparam int   N     = DATA_BYTE_WIDTH;
  localparam cnt_t N_CNT = cnt_t'(N);

  state_t       state;
  logic [W-1:0] r;
  cnt_t         hdr_cnt;
  cnt_t         res_cnt;

  logic [W-1:0]   din_m;
  logic [W-1:0]   hdr_m;
  logic [W-1:0]   r_next;
  logic [W-1:0]   stream_dat;
  logic [W-1:0]   tail_dat;
  logic [2*W-1:0] cat_sh;
  cnt_t           h_in;
  cnt_t           d_cnt;
  cnt_t           sum;
  cnt_t           shift_b;
  logic           fits;

  // r holds residue bytes right-aligned; shifting {r, data} left by N-H bytes lines the residue up at the MSB.
  always_comb begin
    h_in    = keep_to_count(MAX_BYTES'(keep_insert));
    d_cnt   = keep_to_count(MAX_BYTES'(keep_in));
    sum     = hdr_cnt + d_cnt;
    fits    = (sum <= N_CNT);
    shift_b = N_CNT - hdr_cnt;
    din_m   = '0;
    hdr_m   = '0;
    r_next  = '0;
    for (int i = 0; i < N; i++) begin
      din_m[8*i +: 8]  = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
      hdr_m[8*i +: 8]  = keep_insert[i] ? data_insert[8*i +: 8] : 8'h00;
      r_next[8*i +: 8] = (cnt_t'(i) < hdr_cnt) ? din_m[8*i +: 8] : 8'h00;
    end
    cat_sh     = {r, din_m} << {shift_b, 3'b000};
    stream_dat = cat_sh[2*W-1 -: W];
    tail_dat   = r << {shift_b, 3'b000};
  end

  always_comb begin
    valid_out    = 1'b0;
    ready_out    = 1'b0;
    ready_insert = 1'b0;
    data_out     = '0;
    keep_out     = '0;
    last_out     = 1'b0;
    case (state)
      IDLE: begin
        ready_insert = 1'b1;
      end
      STREAM: begin
        valid_out = valid_in;
        ready_out = ready_in;
        data_out  = stream_dat;
        keep_out  = '1;
        if (last_in && fits) begin
          keep_out = DATA_BYTE_WIDTH'(count_to_keep(sum, N));
          last_out = 1'b1;
        end
      end
      TAIL: begin
        valid_out = 1'b1;
        data_out  = tail_dat;
        keep_out  = DATA_BYTE_WIDTH'(count_to_keep(res_cnt, N));
        last_out  = 1'b1;
      end
      default: begin
        ready_insert = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      hdr_cnt <= '0;
      res_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_insert) begin
            r       <= hdr_m;
            hdr_cnt <= h_in;
            res_cnt <= h_in;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (valid_in && ready_in) begin
            r <= r_next;
            if (last_in) begin
              if (fits) begin
                res_cnt <= '0;
                state   <= IDLE;
              end else begin
                res_cnt <= sum - N_CNT;
                state   <= TAIL;
              end
            end
          end
        end
        TAIL: begin
          if (ready_in) begin
            res_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_header_insert.sv
// Bench for axis_header_insert: fixed vectors, stall/reset sequences, and randomized packets vs a byte-queue model.
module tb_axis_header_insert;

  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] k;
    logic         l;
  } beat_t;

  typedef struct {
    logic [W-1:0] hd;
    logic [N-1:0] hk;
    int           np;
    logic [W-1:0] pd [2];
    logic [N-1:0] pk [2];
    int           ne;
    logic [W-1:0] ed [2];
    logic [N-1:0] ek [2];
    logic         el [2];
  } vec_t;

  logic         clk, rst;
  logic         valid_in, last_in, ready_out;
  logic         valid_insert, ready_insert;
  logic         valid_out, last_out, ready_in;
  logic [W-1:0] data_in, data_insert, data_out;
  logic [N-1:0] keep_in, keep_insert, keep_out;

  int pass_cnt  = 0;
  int chk_cnt   = 0;
  int pkts_seen = 0;
  int rd_idx    = 0;
  int exp_pk    = 0;
  bit done      = 0;

  beat_t        out_q[$];
  beat_t        exp_q[$];
  logic [W-1:0] drv_d[$];
  logic [N-1:0] drv_k[$];
  vec_t         tbl[4];

  axis_header_insert #(.DATA_WIDTH(W), .DATA_BYTE_WIDTH(N)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_in(ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accepted output beats, sampled mid-cycle when the handshake at the next edge is certain.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_out && ready_in) begin
        out_q.push_back('{data_out, keep_out, last_out});
        if (last_out) pkts_seen++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    chk_cnt++;
    $display("FAIL %s: got timeout, expected DUT response", nm);
  endtask

  task automatic set_vec(input int i, input logic [W-1:0] hd, input logic [N-1:0] hk, input int np,
                         input logic [W-1:0] pd0, input logic [N-1:0] pk0,
                         input logic [W-1:0] pd1, input logic [N-1:0] pk1, input int ne,
                         input logic [W-1:0] ed0, input logic [N-1:0] ek0, input logic el0,
                         input logic [W-1:0] ed1, input logic [N-1:0] ek1, input logic el1);
    tbl[i].hd = hd; tbl[i].hk = hk; tbl[i].np = np;
    tbl[i].pd[0] = pd0; tbl[i].pk[0] = pk0; tbl[i].pd[1] = pd1; tbl[i].pk[1] = pk1;
    tbl[i].ne = ne;
    tbl[i].ed[0] = ed0; tbl[i].ek[0] = ek0; tbl[i].el[0] = el0;
    tbl[i].ed[1] = ed1; tbl[i].ek[1] = ek1; tbl[i].el[1] = el1;
  endtask

  task automatic load_vec(input int i);
    drv_d.delete(); drv_k.delete(); exp_q.delete();
    for (int j = 0; j < tbl[i].np; j++) begin
      drv_d.push_back(tbl[i].pd[j]);
      drv_k.push_back(tbl[i].pk[j]);
    end
    for (int j = 0; j < tbl[i].ne; j++) exp_q.push_back('{tbl[i].ed[j], tbl[i].ek[j], tbl[i].el[j]});
  endtask

  // Reference: header bytes then payload bytes as one byte stream, cut into N-byte beats.
  task automatic build_model(input logic [W-1:0] hd, input logic [N-1:0] hk);
    logic [7:0] bq[$];
    int h, d, cnt;
    beat_t b;
    exp_q.delete();
    h = $countones(hk);
    for (int j = h - 1; j >= 0; j--) bq.push_back(hd[8*j +: 8]);
    for (int i = 0; i < drv_d.size(); i++) begin
      d = (i == drv_d.size() - 1) ? $countones(drv_k[i]) : N;
      for (int j = 0; j < d; j++) bq.push_back(drv_d[i][W-1-8*j -: 8]);
    end
    while (bq.size() > 0) begin
      b.d = '0;
      b.k = '0;
      cnt = (bq.size() > N) ? N : bq.size();
      for (int j = 0; j < cnt; j++) begin
        b.d[W-1-8*j -: 8] = bq.pop_front();
        b.k[N-1-j] = 1'b1;
      end
      b.l = (bq.size() == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_hdr(input logic [W-1:0] hd, input logic [N-1:0] hk);
    int t;
    data_insert  = hd;
    keep_insert  = hk;
    valid_insert = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready_insert && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("hdr_accept");
    @(posedge clk);
    #1;
    valid_insert = 1'b0;
    data_insert  = $urandom;
  endtask

  task automatic send_beats(input bit gaps);
    int t;
    for (int i = 0; i < drv_d.size(); i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          valid_in = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      valid_in = 1'b1;
      data_in  = drv_d[i];
      keep_in  = drv_k[i];
      last_in  = (i == drv_d.size() - 1);
      t = 0;
      @(negedge clk);
      while (!ready_out && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) timeout_fail("payload_accept");
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (pkts_seen < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (pkts_seen < target) timeout_fail("pkt_done");
    @(posedge clk);
    #1;
  endtask

  task automatic compare_beats(input string nm);
    chk({nm, "_beats"}, 64'(out_q.size() - rd_idx), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && rd_idx + i < out_q.size(); i++) begin
      chk({nm, "_data"}, 64'(out_q[rd_idx+i].d), 64'(exp_q[i].d));
      chk({nm, "_keep"}, 64'(out_q[rd_idx+i].k), 64'(exp_q[i].k));
      chk({nm, "_last"}, 64'(out_q[rd_idx+i].l), 64'(exp_q[i].l));
    end
    rd_idx = out_q.size();
  endtask

  initial begin
    logic [W-1:0] hd;
    logic [N-1:0] hk;
    int h, nb, d;

    set_vec(0, 32'h0000AABB, 4'b0011, 2, 32'h11223344, 4'b1111, 32'h55667788, 4'b1100,
            2, 32'hAABB1122, 4'b1111, 1'b0, 32'h33445566, 4'b1111, 1'b1);
    set_vec(1, 32'h000000CC, 4'b0001, 1, 32'hDDEEFF00, 4'b1110, 32'h0, 4'b0,
            1, 32'hCCDDEEFF, 4'b1111, 1'b1, 32'h0, 4'b0, 1'b0);
    set_vec(2, 32'h00112233, 4'b0111, 1, 32'h44556677, 4'b1100, 32'h0, 4'b0,
            2, 32'h11223344, 4'b1111, 1'b0, 32'h55000000, 4'b1000, 1'b1);
    set_vec(3, 32'h01020304, 4'b1111, 1, 32'hA0B0C0D0, 4'b1000, 32'h0, 4'b0,
            2, 32'h01020304, 4'b1111, 1'b0, 32'hA0000000, 4'b1000, 1'b1);

    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; ready_in = 1'b1;
    #3;
    chk("rst_valid_out", 64'(valid_out), 64'(0));
    chk("rst_ready_out", 64'(ready_out), 64'(0));
    chk("rst_ready_insert", 64'(ready_insert), 64'(1));
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_keep_out", 64'(keep_out), 64'(0));
    chk("rst_last_out", 64'(last_out), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      send_hdr(tbl[v].hd, tbl[v].hk);
      send_beats(1'b0);
      exp_pk++;
      wait_done(exp_pk);
      compare_beats($sformatf("vec%0d", v));
    end

    // Downstream stall for three cycles on the first merged beat.
    load_vec(0);
    send_hdr(tbl[0].hd, tbl[0].hk);
    ready_in = 1'b0;
    valid_in = 1'b1; data_in = tbl[0].pd[0]; keep_in = tbl[0].pk[0]; last_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_valid_out", 64'(valid_out), 64'(1));
      chk("stall_ready_out", 64'(ready_out), 64'(0));
      chk("stall_ready_insert", 64'(ready_insert), 64'(0));
      chk("stall_data_out", 64'(data_out), 64'(32'hAABB1122));
      chk("stall_keep_out", 64'(keep_out), 64'(4'b1111));
      chk("stall_last_out", 64'(last_out), 64'(0));
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    data_in = tbl[0].pd[1]; keep_in = tbl[0].pk[1]; last_in = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
    exp_pk++;
    wait_done(exp_pk);
    compare_beats("stall");

    // Reset while a packet is in STREAM, then a clean packet.
    send_hdr(32'h0000AABB, 4'b0011);
    ready_in = 1'b0;
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'b1111; last_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid_out", 64'(valid_out), 64'(0));
    chk("midrst_ready_insert", 64'(ready_insert), 64'(1));
    chk("midrst_ready_out", 64'(ready_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    @(posedge clk); #1;
    load_vec(1);
    send_hdr(tbl[1].hd, tbl[1].hk);
    send_beats(1'b0);
    exp_pk++;
    wait_done(exp_pk);
    compare_beats("after_rst");

    fork
      begin
        for (int p = 0; p < 30; p++) begin
          h  = $urandom_range(1, N);
          hk = N'((1 << h) - 1);
          hd = $urandom;
          nb = $urandom_range(1, 4);
          d  = $urandom_range(1, N);
          drv_d.delete(); drv_k.delete();
          for (int i = 0; i < nb; i++) begin
            drv_d.push_back($urandom);
            drv_k.push_back((i == nb - 1) ? N'(4'hF << (N - d)) : 4'hF);
          end
          build_model(hd, hk);
          send_hdr(hd, hk);
          send_beats(1'b1);
          exp_pk++;
          wait_done(exp_pk);
          compare_beats($sformatf("rnd%0d", p));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ready_in = ($urandom_range(0, 3) != 0);
        end
        ready_in = 1'b1;
      end
    join

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
